// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frames a start/8-data/optional-parity/stop sequence from
// oversampled edge counts and steers the data sampler and deserializer.
module uart_rx_ctrl (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic       sampled_bit,
   input  logic [5:0] Prescale,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   output logic [5:0] edge_cnt,
   output logic [3:0] bit_cnt,
   output logic       dat_samp_en,
   output logic       deser_en,
   output logic       Fill,
   output logic       data_valid,
   output logic       deser_clr,
   output logic       par_err,
   output logic       stp_err,
   output logic       strt_glitch
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_OUT    = 3'd5
   } state_e;

   state_e     state_q, state_d;
   logic [5:0] ps_q, ps_d;
   logic       par_en_q, par_en_d;
   logic       par_typ_q, par_typ_d;
   logic [5:0] edge_q, edge_d;
   logic [3:0] bit_q, bit_d;
   logic       par_acc_q, par_acc_d;
   logic       frm_perr_q, frm_perr_d;
   logic       par_err_q, par_err_d;
   logic       stp_err_q, stp_err_d;
   logic       glitch_q, glitch_d;

   logic       last_edge;
   logic       counting;
   logic       enter_start;
   logic [5:0] ps_eff;

   assign last_edge   = (edge_q == (ps_q - 6'd1));
   assign counting    = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PARITY) || (state_q == S_STOP);
   assign enter_start = (state_d == S_START) && (state_q != S_START);

   // Unsupported oversampling ratios fall back to 8.
   always_comb begin
      case (Prescale)
         6'd8, 6'd16, 6'd32: ps_eff = Prescale;
         default:            ps_eff = 6'd8;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!RX_IN) state_d = S_START;
         end
         S_START: begin
            if (last_edge) state_d = sampled_bit ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (last_edge && (bit_q == 4'd8)) state_d = par_en_q ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (last_edge) state_d = S_STOP;
         end
         S_STOP: begin
            if (last_edge) state_d = S_OUT;
         end
         S_OUT: begin
            state_d = RX_IN ? S_IDLE : S_START;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dat_samp_en = counting;
      deser_en    = (state_q == S_DATA);
      Fill        = (state_q == S_DATA) && last_edge;
      data_valid  = (state_q == S_OUT) && !(par_err_q || stp_err_q);
      deser_clr   = (state_q == S_OUT) && (par_err_q || stp_err_q);
      edge_cnt    = edge_q;
      bit_cnt     = bit_q;
      par_err     = par_err_q;
      stp_err     = stp_err_q;
      strt_glitch = glitch_q;
   end

   always_comb begin
      ps_d       = ps_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      edge_d     = edge_q;
      bit_d      = bit_q;
      par_acc_d  = par_acc_q;
      frm_perr_d = frm_perr_q;
      par_err_d  = par_err_q;
      stp_err_d  = stp_err_q;
      glitch_d   = 1'b0;

      if (enter_start) begin
         ps_d       = ps_eff;
         par_en_d   = PAR_EN;
         par_typ_d  = PAR_TYP;
         edge_d     = 6'd0;
         bit_d      = 4'd0;
         par_acc_d  = 1'b0;
         frm_perr_d = 1'b0;
      end else if (counting) begin
         if (last_edge) begin
            edge_d = 6'd0;
            bit_d  = bit_q + 4'd1;
         end else begin
            edge_d = edge_q + 6'd1;
         end
      end

      // Counters rest at zero whenever the frame is not being timed.
      if ((state_d == S_IDLE) || (state_d == S_OUT)) begin
         edge_d = 6'd0;
         bit_d  = 4'd0;
      end

      if (Fill) par_acc_d = par_acc_q ^ sampled_bit;

      if ((state_q == S_PARITY) && last_edge)
         frm_perr_d = sampled_bit ^ par_acc_q ^ par_typ_q;

      // Flags are loaded on the way into OUT so they are already visible there.
      if ((state_q == S_STOP) && last_edge) begin
         par_err_d = frm_perr_q;
         stp_err_d = ~sampled_bit;
      end

      if ((state_q == S_START) && last_edge && sampled_bit) glitch_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ps_q       <= 6'd0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         edge_q     <= 6'd0;
         bit_q      <= 4'd0;
         par_acc_q  <= 1'b0;
         frm_perr_q <= 1'b0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
         glitch_q   <= 1'b0;
      end else begin
         ps_q       <= ps_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         edge_q     <= edge_d;
         bit_q      <= bit_d;
         par_acc_q  <= par_acc_d;
         frm_perr_q <= frm_perr_d;
         par_err_q  <= par_err_d;
         stp_err_q  <= stp_err_d;
         glitch_q   <= glitch_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a frame-timing model derived from bit/edge
// arithmetic is compared every cycle, plus literal latency and flag expectations.
module tb_uart_rx_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic       sampled_bit = 1'b1;
   logic [5:0] Prescale = 6'd8;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       dat_samp_en, deser_en, Fill, data_valid, deser_clr;
   logic       par_err, stp_err, strt_glitch;

   uart_rx_ctrl dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .sampled_bit(sampled_bit),
      .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
      .deser_en(deser_en), .Fill(Fill), .data_valid(data_valid),
      .deser_clr(deser_clr), .par_err(par_err), .stp_err(stp_err),
      .strt_glitch(strt_glitch)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame model: position in the frame is just the cycle offset t since START entry.
   bit         m_active = 0, m_pe = 0, m_pt = 0, m_out = 0, m_glitch = 0;
   bit         m_fperr = 0, m_fserr = 0, m_operr = 0, m_oserr = 0;
   int         m_t = 0, m_P = 8;
   logic [7:0] m_data = 8'h00;

   initial begin
      forever begin
         @(posedge CLK or negedge RST);
         if (!RST) begin
            m_active = 0; m_out = 0; m_glitch = 0; m_t = 0;
            m_fperr = 0; m_fserr = 0; m_operr = 0; m_oserr = 0;
         end else begin
            bit out_n, gl_n;
            int b;
            out_n = 0; gl_n = 0;
            if (m_active) begin
               b = m_t / m_P;
               if ((m_t % m_P) == m_P - 1) begin
                  if (b == 0 && sampled_bit) begin
                     m_active = 0; gl_n = 1;
                  end else if (b >= 1 && b <= 8) begin
                     m_data[b-1] = sampled_bit;
                  end else if (m_pe && b == 9) begin
                     m_fperr = (sampled_bit != ((^m_data) ^ m_pt));
                  end
                  if (m_active && b == 9 + m_pe) begin
                     m_fserr = !sampled_bit;
                     m_active = 0; out_n = 1;
                     m_operr = m_fperr; m_oserr = m_fserr;
                  end
               end
               m_t++;
            end else if (!RX_IN) begin
               m_active = 1; m_t = 0;
               m_P = (Prescale == 8 || Prescale == 16 || Prescale == 32) ? int'(Prescale) : 8;
               m_pe = PAR_EN; m_pt = PAR_TYP;
               m_data = 8'h00; m_fperr = 0; m_fserr = 0;
            end
            m_out = out_n;
            m_glitch = gl_n;
         end
      end
   end

   // Event records taken from the DUT for the literal expectations.
   int         fill_total = 0, dv_total = 0, clr_total = 0, glitch_total = 0;
   int         last_dv_cyc = -1, last_clr_cyc = -1, last_glitch_cyc = -1;
   int         dv_q[$];
   logic [7:0] cap = 8'h00;

   initial begin
      forever begin
         int e_edge, e_bit;
         bit e_samp, e_deser, e_fill;
         @(negedge CLK);
         e_edge = 0; e_bit = 0; e_samp = 0; e_deser = 0; e_fill = 0;
         if (m_active) begin
            e_edge  = m_t % m_P;
            e_bit   = m_t / m_P;
            e_samp  = 1;
            e_deser = (e_bit >= 1 && e_bit <= 8);
            e_fill  = e_deser && (e_edge == m_P - 1);
         end
         check("edge_cnt", edge_cnt, e_edge);
         check("bit_cnt", bit_cnt, e_bit);
         check("dat_samp_en", dat_samp_en, e_samp);
         check("deser_en", deser_en, e_deser);
         check("Fill", Fill, e_fill);
         check("data_valid", data_valid, m_out && !(m_operr || m_oserr));
         check("deser_clr", deser_clr, m_out && (m_operr || m_oserr));
         check("par_err", par_err, m_operr);
         check("stp_err", stp_err, m_oserr);
         check("strt_glitch", strt_glitch, m_glitch);
         check("pulse_overlap", ($countones({data_valid, deser_clr, Fill, strt_glitch}) > 1), 0);
         if (Fill) begin fill_total++; cap = {sampled_bit, cap[7:1]}; end
         if (data_valid) begin dv_total++; last_dv_cyc = cyc; dv_q.push_back(cyc); end
         if (deser_clr) begin clr_total++; last_clr_cyc = cyc; end
         if (strt_glitch) begin glitch_total++; last_glitch_cyc = cyc; end
      end
   end

   // Called at a negedge while the DUT is idle or in OUT; returns at the OUT negedge
   // (full frame) or at the negedge of offset max_t-1 (aborted frame).
   task automatic run_frame(input int p_in, input bit pe, input bit pt, input logic [7:0] d,
                            input bit pbit, input bit sbit, input int max_t, output int start_c);
      int   p, len;
      logic b [0:10];
      p   = (p_in == 8 || p_in == 16 || p_in == 32) ? p_in : 8;
      len = p * (10 + pe);
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) b[i+1] = d[i];
      b[9]  = pe ? pbit : sbit;
      b[10] = pe ? sbit : 1'b1;
      Prescale = p_in[5:0]; PAR_EN = pe; PAR_TYP = pt;
      RX_IN = 1'b0; sampled_bit = 1'b1;
      start_c = cyc + 1;
      for (int t = 0; t < len && t < max_t; t++) begin
         @(negedge CLK);
         RX_IN = b[t/p]; sampled_bit = b[t/p];
         // Disturb the configuration mid-frame; the latched copy must govern.
         if (t == 1) begin Prescale = 6'd20; PAR_EN = ~pe; PAR_TYP = ~pt; end
      end
      if (max_t >= len) @(negedge CLK);
   endtask

   task automatic go_idle(input int n);
      RX_IN = 1'b1; sampled_bit = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   localparam int FULL = 100000;

   initial begin
      int s, s1, s2, f0, d0, c0, g0;
      repeat (3) @(negedge CLK);
      check("reset_state", {edge_cnt, bit_cnt, dat_samp_en, deser_en, Fill, data_valid,
                            deser_clr, par_err, stp_err, strt_glitch}, 0);
      RST = 1'b1;
      go_idle(3);

      // Even parity, good frame, byte A5.
      f0 = fill_total; d0 = dv_total;
      run_frame(8, 1, 0, 8'hA5, 0, 1, FULL, s);
      go_idle(4);
      check("A_dv_latency", last_dv_cyc - s, 88);
      check("A_dv_count", dv_total - d0, 1);
      check("A_fill_count", fill_total - f0, 8);
      check("A_byte", cap, 8'hA5);
      check("A_par_err", par_err, 0);
      check("A_stp_err", stp_err, 0);

      // Same byte, wrong parity bit.
      d0 = dv_total; c0 = clr_total;
      run_frame(8, 1, 0, 8'hA5, 1, 1, FULL, s);
      go_idle(4);
      check("B_clr_latency", last_clr_cyc - s, 88);
      check("B_clr_count", clr_total - c0, 1);
      check("B_dv_count", dv_total - d0, 0);
      check("B_par_err", par_err, 1);
      check("B_stp_err", stp_err, 0);

      // Prescale 16, no parity, stop bit low.
      run_frame(16, 0, 0, 8'h5A, 0, 0, FULL, s);
      go_idle(4);
      check("C_clr_latency", last_clr_cyc - s, 160);
      check("C_stp_err", stp_err, 1);
      check("C_par_err", par_err, 0);

      // False start: low for 3 cycles, sampled high at edge 7.
      f0 = fill_total; g0 = glitch_total; d0 = dv_total; c0 = clr_total;
      Prescale = 6'd8; RX_IN = 1'b0; sampled_bit = 1'b1; s = cyc + 1;
      for (int t = 0; t < 8; t++) begin
         @(negedge CLK);
         RX_IN = (t < 2) ? 1'b0 : 1'b1;
      end
      go_idle(3);
      check("D_glitch_latency", last_glitch_cyc - s, 8);
      check("D_glitch_count", glitch_total - g0, 1);
      check("D_fill_count", fill_total - f0, 0);
      check("D_no_out", (dv_total - d0) + (clr_total - c0), 0);

      // Back-to-back: second START follows OUT directly, so pulses land 89 edges
      // apart (88 frame cycles plus the single OUT cycle).
      run_frame(8, 1, 0, 8'hC3, 0, 1, FULL, s1);
      run_frame(8, 1, 0, 8'h81, 0, 1, FULL, s2);
      go_idle(4);
      check("E_dv2_latency", dv_q[$] - s2, 88);
      check("E_dv1_latency", dv_q[$-1] - s1, 88);
      check("E_dv_spacing", dv_q[$] - dv_q[$-1], 89);
      check("E_byte2", cap, 8'h81);

      // Unsupported Prescale (12) behaves as 8; odd parity good frame.
      run_frame(12, 1, 1, 8'h3C, 1, 1, FULL, s);
      go_idle(4);
      check("F_dv_latency", last_dv_cyc - s, 88);
      check("F_byte", cap, 8'h3C);
      check("F_par_err", par_err, 0);

      // Prescale 32, no parity.
      run_frame(32, 0, 1, 8'hFF, 0, 1, FULL, s);
      go_idle(4);
      check("F32_dv_latency", last_dv_cyc - s, 320);
      check("F32_byte", cap, 8'hFF);

      // Reset mid-frame at bit 4, then a clean frame.
      d0 = dv_total; c0 = clr_total;
      run_frame(8, 1, 0, 8'hA5, 0, 1, 4 * 8 + 3, s);
      @(negedge CLK);
      check("G_bit_at_abort", bit_cnt, 4);
      #2 RST = 1'b0;
      #1 check("G_reset_immediate", {edge_cnt, bit_cnt, dat_samp_en, deser_en, Fill, data_valid,
                                     deser_clr, par_err, stp_err, strt_glitch}, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      go_idle(3);
      check("G_no_out", (dv_total - d0) + (clr_total - c0), 0);
      run_frame(8, 1, 1, 8'h3C, 1, 1, FULL, s);
      go_idle(4);
      check("G_dv_latency", last_dv_cyc - s, 88);
      check("G_byte", cap, 8'h3C);
      check("G_dv_count", dv_total - d0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
